mux_nto1_scan: RTL and testbench
================================

# mux_nto1_scan

Parameterised, registered N-to-1 channel multiplexer that generalises the fixed 4-to-1 gate-level mux to NCH channels of W bits each. It has two modes:
- **Direct mode:** selection comes from `sel`.
- **Scan mode:** an internal sequencer steps through the channels enabled in `mask`, holding each channel for DWELL enabled cycles.

The block sits in front of the shared monitor/readout path so that one consumer can observe many sources.

## Interface
- `NCH`, default 4: number of channels, ≥2.
- `W`, default 1: channel data width, ≥1.
- `DWELL`, default 4: enabled cycles per channel in scan mode, ≥1.
- `SW` (localparam): `$clog2(NCH)`, the width of channel indices.

Ports (clock and reset first):
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: update enable. When 0, all state holds.
- `mode` in 1: 0 = direct, 1 = scan. Sampled only on `en` edges.
- `sel` in SW: channel index used in direct mode.
- `mask` in NCH: per-channel scan enable. Ignored in direct mode.
- `din` in NCH*W: channel k occupies `din[k*W +: W]`.
- `dout` out W: registered selected data.
- `cur_ch` out SW: index of the channel currently shown on `dout`.
- `valid` out 1: `dout`/`cur_ch` hold a legitimate channel sample.
- `wrap` out 1: one-cycle pulse marking the first sample of a new scan lap.

## Operation
- **Internal state:** FSM {DIRECT, SCAN_START, SCAN_RUN}, pointer `ptr` (SW bits), dwell counter `cnt` (`$clog2(DWELL+1)` bits).
- **Edge with `en`=0:** nothing changes (`dout`, `cur_ch`, `valid`, `ptr`, `cnt`, state); `wrap` <= 0.
- **DIRECT (`mode`=0):**
  - Each `en` edge: `dout` <= `din[sel]`, `cur_ch` <= `sel`, `valid` <= 1, `cnt` <= 0, `wrap` <= 0.
  - `sel` ≥ NCH (non-power-of-two NCH): `dout` and `cur_ch` hold, `valid` <= 0.
- **`mode` 0→1 on an `en` edge:** go to SCAN_START.
- **SCAN_START:** `ptr_eff` = lowest set bit of `mask`. Load as in a run edge, then go to SCAN_RUN. `wrap` is not asserted on entry.
- **SCAN_RUN `ptr_eff`:** `ptr`, unless `mask[ptr]`=0, in which case the next set mask bit strictly after `ptr`, cyclically. A skip caused by masking counts as an advance and restarts dwell.
- **SCAN_RUN edge:**
  - `dout` <= `din[ptr_eff]`, `cur_ch` <= `ptr_eff`, `valid` <= 1.
  - If `cnt`==DWELL-1: `ptr` <= next set mask bit strictly after `ptr_eff`, cyclically, and `cnt` <= 0. Otherwise `ptr` <= `ptr_eff` and `cnt` <= `cnt`+1.
  - `wrap` <= 1 when the channel loaded into `cur_ch` was reached by a cyclic advance to an index ≤ the previous `cur_ch`; otherwise 0.
- **Single unmasked channel:** the next channel is itself, so `wrap` pulses once every DWELL enabled cycles.
- **`mask` all zero (scan):** `dout` and `cur_ch` hold, `valid` <= 0, `cnt` <= 0, `wrap` <= 0, and the FSM goes to SCAN_START. The next `en` edge with a nonzero `mask` loads the lowest set bit.
- **`mode` 1→0 on an `en` edge:** behaves as DIRECT on that same edge; `cnt` cleared.
- **`mask` change mid-dwell:** takes effect on the next `en` edge. A still-enabled current channel keeps its remaining dwell.
- **DWELL=1:** advance on every `en` edge.

## Timing
- **Reset (async, immediate):** `dout`=0, `cur_ch`=0, `valid`=0, `wrap`=0, `ptr`=0, `cnt`=0, state=DIRECT. Outputs are released on the first edge after `rst_n` rises. Reset mid-scan discards the lap; no `wrap`.
- **Latency:** `din`/`sel` to `dout` is one `en` edge.
- **Dwell:** in scan, each enabled channel appears on `dout` for exactly DWELL consecutive `en` edges; `cur_ch` is always aligned with `dout`.
- **Stalls:** `en` gaps do not consume dwell.
- **`wrap` alignment:** high only in the cycle coinciding with the first sample of a lap; never high in two consecutive cycles when DWELL>1.
- **Purity:** no combinational path from inputs to outputs.

## Test plan
Common setup: NCH=4, W=8, DWELL=2, `din` = ch3..ch0 = {8'h44, 8'h33, 8'h22, 8'h11}, `en`=1 unless stated.

1. **Async reset:** drive `rst_n`=0 mid-scan, between edges → `dout`=8'h00, `cur_ch`=0, `valid`=0, `wrap`=0 immediately. Release `rst_n` → outputs stay at those values until the first `en` edge.
2. **Direct mode:** `mode`=0, `sel`=2 → next edge `dout`=8'h33, `cur_ch`=2, `valid`=1. Then `sel`=1 → one edge later `dout`=8'h22.
3. **Full scan:** `mode`=1, `mask`=4'b1111 → `cur_ch` per edge 0,0,1,1,2,2,3,3,0,0, `dout` tracking 11,11,22,22,33,33,44,44,11,11. `wrap`=1 only at the second 0-entry (edge 9).
4. **Sparse and single-channel masks:** `mask`=4'b1010 → `cur_ch` 1,1,3,3,1,1 with `wrap` on the return to 1. `mask`=4'b0100 → `cur_ch` 2 constant, `wrap` on every second edge after entry.
5. **Masking and empty mask:**
   - Clearing `mask[cur_ch]` mid-dwell → next edge shows the next enabled channel with a fresh dwell.
   - `mask`=0 → `valid`=0, `dout`/`cur_ch` hold.
   - `mask`=4'b0001 → next edge `cur_ch`=0, `valid`=1, `dout`=8'h11.
6. **Stall:** `en`=0 for 3 cycles after the first sample of ch1 → all outputs hold and `wrap`=0. On resume: one more ch1 sample, then ch2.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered NCH-to-1 channel mux with direct select and masked round-robin scan
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update enable; all state holds when low
//   mode       : 0 = direct (sel), 1 = scan over mask with DWELL samples per channel
//   sel, mask  : direct channel index, per-channel scan enable
//   din        : NCH packed channels, channel k at din[k*W +: W]
//   dout       : registered selected data, cur_ch its channel index
//   valid      : dout/cur_ch hold a legitimate sample
//   wrap       : one-cycle pulse on the first sample of a new scan lap
module mux_nto1_scan #(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int DWELL = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [NCH-1:0] mask,
  input  logic [NCH*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  cur_ch,
  output logic           valid,
  output logic           wrap
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {DIRECT, SCAN_START, SCAN_RUN} state_t;
  state_t state, state_nx;
  logic [SW-1:0] ptr, ptr_nx, ptr_eff, nxt_eff, cur_ch_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_eff;
  logic [W-1:0] ch [NCH];
  logic [W-1:0] dout_nx;
  logic valid_nx, wrap_nx, start, skip, last;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch[k] = din[k*W +: W];
  end

  // First set bit of m strictly after p, cyclically; p itself if it is the only one.
  function automatic logic [SW-1:0] next_set(input logic [NCH-1:0] m, input logic [SW-1:0] p);
    logic [SW-1:0] r;
    logic hit;
    r = p;
    hit = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      int idx;
      idx = (int'(p) + i) % NCH;
      if (!hit && m[SW'(idx)]) begin
        r = SW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIRECT;
      ptr <= '0;
      cnt <= '0;
      dout <= '0;
      cur_ch <= '0;
      valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      dout <= dout_nx;
      cur_ch <= cur_ch_nx;
      valid <= valid_nx;
      wrap <= wrap_nx;
    end
  end

  // Any scan edge not already in SCAN_RUN behaves as a lap start.
  always_comb begin
    state_nx = !en ? state : !mode ? DIRECT : (mask == '0) ? SCAN_START : SCAN_RUN;
  end

  always_comb begin
    start = state != SCAN_RUN;
    skip = !start && !mask[ptr];
    ptr_eff = start ? next_set(mask, SW'(NCH - 1)) : skip ? next_set(mask, ptr) : ptr;
    cnt_eff = (start || skip) ? '0 : cnt;
    nxt_eff = next_set(mask, ptr_eff);
    last = cnt_eff == CW'(DWELL - 1);
    dout_nx = dout;
    cur_ch_nx = cur_ch;
    valid_nx = valid;
    wrap_nx = 1'b0;
    ptr_nx = ptr;
    cnt_nx = cnt;
    if (en) begin
      if (!mode) begin
        cnt_nx = '0;
        valid_nx = int'(sel) < NCH;
        dout_nx = valid_nx ? ch[sel] : dout;
        cur_ch_nx = valid_nx ? sel : cur_ch;
      end else if (mask == '0) begin
        valid_nx = 1'b0;
        cnt_nx = '0;
      end else begin
        dout_nx = ch[ptr_eff];
        cur_ch_nx = ptr_eff;
        valid_nx = 1'b1;
        // A fresh dwell that lands at or below the previous channel closes a lap.
        wrap_nx = !start && cnt_eff == '0 && ptr_eff <= cur_ch;
        ptr_nx = last ? nxt_eff : ptr_eff;
        cnt_nx = last ? '0 : cnt_eff + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: directed and random checks of mux_nto1_scan against a sample-level model
module tb_mux_nto1_scan;
  localparam int NCH = 4;
  localparam int W = 8;
  localparam int DWELL = 2;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [NCH-1:0] mask = '0;
  logic [NCH*W-1:0] din;
  logic [W-1:0] dout;
  logic [SW-1:0] cur_ch;
  logic valid, wrap;
  logic [W-1:0] chv [NCH];
  int total = 0;
  int bad = 0;
  logic [W-1:0] m_dout;
  int m_cur, m_ptr, m_shown;
  bit m_valid, m_wrap, m_scan;

  always #5 clk = ~clk;

  mux_nto1_scan #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .din(din), .dout(dout), .cur_ch(cur_ch), .valid(valid), .wrap(wrap)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int nextset(input logic [NCH-1:0] m, input int p);
    for (int i = 1; i <= NCH; i++) begin
      int idx = (p + i) % NCH;
      if (m[idx[1:0]]) return idx;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_dout = '0;
    m_cur = 0;
    m_valid = 1'b0;
    m_wrap = 1'b0;
    m_scan = 1'b0;
    m_ptr = 0;
    m_shown = 0;
  endtask

  // Scan as a channel pointer plus count of samples already shown in the current dwell.
  task automatic model_edge();
    int p;
    bit fresh;
    m_wrap = 1'b0;
    if (!en) return;
    if (!mode) begin
      m_dout = chv[sel];
      m_cur = int'(sel);
      m_valid = 1'b1;
      m_scan = 1'b0;
      m_shown = 0;
    end else if (mask == '0) begin
      m_valid = 1'b0;
      m_scan = 1'b0;
      m_shown = 0;
    end else begin
      if (!m_scan) begin
        p = nextset(mask, NCH - 1);
        fresh = 1'b1;
      end else if (!mask[m_ptr[1:0]]) begin
        p = nextset(mask, m_ptr);
        fresh = 1'b1;
      end else begin
        p = m_ptr;
        fresh = m_shown == 0;
      end
      m_wrap = m_scan && fresh && p <= m_cur;
      m_shown = fresh ? 1 : m_shown + 1;
      m_ptr = p;
      if (m_shown == DWELL) begin
        m_ptr = nextset(mask, p);
        m_shown = 0;
      end
      m_dout = chv[p[1:0]];
      m_cur = p;
      m_valid = 1'b1;
      m_scan = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".dout"}, int'(dout), int'(m_dout));
    chk({tag, ".cur_ch"}, int'(cur_ch), m_cur);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic set_din();
    din = {chv[3], chv[2], chv[1], chv[0]};
  endtask

  int exp3 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    chv[0] = 8'h11;
    chv[1] = 8'h22;
    chv[2] = 8'h33;
    chv[3] = 8'h44;
    set_din();
    model_reset();
    #12;
    check_outs("por");
    @(negedge clk);
    rst_n = 1'b1;
    step("release");
    en = 1'b1;
    mode = 1'b0;
    sel = 2'd2;
    step("dir2");
    chk("dir2.const", int'(dout), 8'h33);
    sel = 2'd1;
    step("dir1");
    chk("dir1.const", int'(dout), 8'h22);
    mode = 1'b1;
    mask = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step("scan");
      chk("scan.cur_const", int'(cur_ch), exp3[i]);
      chk("scan.wrap_const", int'(wrap), int'(i == 8));
    end
    mask = 4'b1010;
    for (int i = 0; i < 6; i++) step("sparse");
    mask = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step("single");
      chk("single.cur_const", int'(cur_ch), 2);
    end
    mode = 1'b0;
    sel = 2'd3;
    step("pre5");
    mode = 1'b1;
    mask = 4'b1111;
    step("m5.ch0");
    mask = 4'b1110;
    step("m5.skip");
    chk("m5.skip_const", int'(cur_ch), 1);
    step("m5.ch1b");
    step("m5.ch2");
    chk("m5.ch2_const", int'(cur_ch), 2);
    mask = 4'b0000;
    step("m5.empty");
    chk("m5.empty_valid", int'(valid), 0);
    chk("m5.empty_hold", int'(cur_ch), 2);
    step("m5.empty2");
    mask = 4'b0001;
    step("m5.one");
    chk("m5.one_dout", int'(dout), 8'h11);
    chk("m5.one_valid", int'(valid), 1);
    mode = 1'b0;
    step("pre6");
    mode = 1'b1;
    mask = 4'b1111;
    step("st.a");
    step("st.b");
    step("st.c");
    chk("st.ch1_const", int'(cur_ch), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.cur_const", int'(cur_ch), 1);
      chk("stall.wrap_const", int'(wrap), 0);
    end
    en = 1'b1;
    step("st.d");
    chk("st.d_const", int'(cur_ch), 1);
    step("st.e");
    chk("st.e_const", int'(cur_ch), 2);
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 7) != 0;
      mode = $urandom_range(0, 5) != 0;
      sel = SW'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 3) == 0) mask = NCH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) chv[$urandom_range(0, NCH - 1)] = W'($urandom);
      set_din();
      step("rnd");
    end
    mode = 1'b1;
    mask = 4'b1111;
    en = 1'b1;
    step("r1.a");
    step("r1.b");
    step("r1.c");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("arst");
    chk("arst.dout_const", int'(dout), 0);
    @(posedge clk);
    #1;
    check_outs("arst.held");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    step("arst.rel");
    en = 1'b1;
    step("arst.first");
    chk("arst.first_const", int'(cur_ch), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
